mem_port_arbiter: RTL and testbench

Shares one single-ported synchronous SRAM between the pipelined core's instruction-fetch port and data-memory port. Arbitrates each cycle with data priority and a starvation guard for fetch. Returns read data one cycle after grant and provides grant signals the core uses as stall sources (fetch stall on `!if_gnt`, memory-stage stall on `!d_gnt`). Sits between the core and the unified on-chip memory in the tiny SoC.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_wait_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
// The response owner is an IF flag plus a separate data field, so that one cycle can return both.
package mem_arb_pkg;

  localparam int AW_DEFAULT   = 12;
  localparam int MAX_WAIT_MIN = 1;
  localparam int MAX_WAIT_MAX = 15;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D_RD = 2'd1,
    OWN_D_WR = 2'd2,
    OWN_DERR = 2'd3
  } d_owner_e;

  typedef struct packed {
    logic     if_own;
    d_owner_e d_own;
  } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Fetch starvation guard: counts consecutive denied fetch cycles down from MAX_WAIT.
// starved is raised at terminal count, which means fetch has waited MAX_WAIT cycles.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [WAIT_W-1:0] TC_LOAD = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] remain_q;

  // remain_q == TC_LOAD corresponds to zero waits; it holds at zero (saturation).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain_q <= TC_LOAD;
    end else if (clr) begin
      remain_q <= TC_LOAD;
    end else if (inc && (remain_q != '0)) begin
      remain_q <= remain_q - 1'b1;
    end
  end

  assign starved = (remain_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and data memory ports.
// Data has priority. Fetch wins after MAX_WAIT denials. Responses arrive one cycle after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  logic   d_misaligned;
  logic   d_needs_sram;
  logic   starved;
  logic   wait_inc;
  logic   wait_clr;
  owner_t owner_d;
  owner_t owner_q;

  // Upper address bits alias, and the fetch byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};

  assign d_misaligned = d_req && (d_addr[1:0] != 2'b00);
  assign d_needs_sram = d_req && !d_misaligned;

  assign if_gnt = if_req && (!d_needs_sram || starved);
  assign d_gnt  = d_misaligned || (d_needs_sram && !if_gnt);

  assign wait_inc = if_req && !if_gnt;
  assign wait_clr = if_gnt || !if_req;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .inc     (wait_inc),
    .clr     (wait_clr),
    .starved (starved)
  );

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (if_gnt) begin
      sram_en   = 1'b1;
      sram_be   = 4'b1111;
      sram_addr = if_addr[AW+1:2];
    end else if (d_needs_sram && d_gnt) begin
      sram_en    = 1'b1;
      sram_we    = d_we;
      sram_be    = d_we ? d_be : 4'b1111;
      sram_addr  = d_addr[AW+1:2];
      sram_wdata = d_wdata;
    end
  end

  always_comb begin
    owner_d.if_own = if_gnt;
    owner_d.d_own  = OWN_NONE;
    if (d_gnt) begin
      if (d_misaligned) begin
        owner_d.d_own = OWN_DERR;
      end else if (d_we) begin
        owner_d.d_own = OWN_D_WR;
      end else begin
        owner_d.d_own = OWN_D_RD;
      end
    end
  end

  // Reset clears the owner immediately, so a response in flight is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '{if_own: 1'b0, d_own: OWN_NONE};
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = owner_q.if_own;
  assign if_rdata  = owner_q.if_own ? sram_rdata : 32'h0;
  assign d_rvalid  = (owner_q.d_own != OWN_NONE);
  assign d_err     = (owner_q.d_own == OWN_DERR);
  assign d_rdata   = (owner_q.d_own == OWN_D_RD) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous SRAM.
// Word i of the SRAM starts as 32'hC0DE_0000 | i.
module tb_mem_port_arbiter;

  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          sram_en;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    reset = 1'b1;
    tick();

    // Fetch only, three back-to-back grants at word 4.
    if_req  = 1'b1;
    if_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("if_only_gnt", 32'(if_gnt), 32'd1);
      chk("if_only_d_gnt", 32'(d_gnt), 32'd0);
      chk("if_only_en", 32'(sram_en), 32'd1);
      chk("if_only_addr", 32'(sram_addr), 32'd4);
      chk("if_only_be", 32'(sram_be), 32'hF);
      chk("if_only_we", 32'(sram_we), 32'd0);
      tick();
      chk("if_only_rvalid", 32'(if_rvalid), 32'd1);
      chk("if_only_rdata", if_rdata, 32'hC0DE_0004);
    end
    if_req = 1'b0;
    #1;
    chk("idle_en", 32'(sram_en), 32'd0);
    chk("idle_addr", 32'(sram_addr), 32'd0);
    chk("idle_be", 32'(sram_be), 32'd0);
    tick();
    chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("idle_if_rdata", if_rdata, 32'h0);

    // Contention: four data grants then one forced fetch grant, repeating.
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_addr  = 32'h30;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i % 5 == 4) begin
        chk("cont_if_gnt_f", 32'(if_gnt), 32'd1);
        chk("cont_d_gnt_f", 32'(d_gnt), 32'd0);
        chk("cont_addr_f", 32'(sram_addr), 32'd16);
      end else begin
        chk("cont_if_gnt_d", 32'(if_gnt), 32'd0);
        chk("cont_d_gnt_d", 32'(d_gnt), 32'd1);
        chk("cont_addr_d", 32'(sram_addr), 32'd12);
      end
      tick();
      if (i % 5 == 4) begin
        chk("cont_if_rvalid_f", 32'(if_rvalid), 32'd1);
        chk("cont_d_rvalid_f", 32'(d_rvalid), 32'd0);
        chk("cont_if_rdata_f", if_rdata, 32'hC0DE_0010);
        chk("cont_d_rdata_f", d_rdata, 32'h0);
      end else begin
        chk("cont_if_rvalid_d", 32'(if_rvalid), 32'd0);
        chk("cont_d_rvalid_d", 32'(d_rvalid), 32'd1);
        chk("cont_d_rdata_d", d_rdata, 32'hC0DE_000C);
        chk("cont_if_rdata_d", if_rdata, 32'h0);
      end
    end
    idle_inputs();
    tick();

    // Partial write then read back.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_be    = 4'b0011;
    d_wdata = 32'hA5A5_1234;
    #1;
    chk("wr_gnt", 32'(d_gnt), 32'd1);
    chk("wr_we", 32'(sram_we), 32'd1);
    chk("wr_be", 32'(sram_be), 32'h3);
    chk("wr_addr", 32'(sram_addr), 32'd8);
    chk("wr_wdata", sram_wdata, 32'hA5A5_1234);
    tick();
    chk("wr_rvalid", 32'(d_rvalid), 32'd1);
    chk("wr_rdata", d_rdata, 32'h0);
    chk("wr_err", 32'(d_err), 32'd0);
    d_we = 1'b0;
    d_be = 4'h0;
    #1;
    chk("rd_gnt", 32'(d_gnt), 32'd1);
    chk("rd_we", 32'(sram_we), 32'd0);
    tick();
    chk("rd_rvalid", 32'(d_rvalid), 32'd1);
    chk("rd_rdata", d_rdata, 32'hC0DE_1234);

    // Misaligned data read alongside a fetch: both granted together.
    d_addr  = 32'h22;
    if_req  = 1'b1;
    if_addr = 32'h40;
    #1;
    chk("mis_d_gnt", 32'(d_gnt), 32'd1);
    chk("mis_if_gnt", 32'(if_gnt), 32'd1);
    chk("mis_addr", 32'(sram_addr), 32'd16);
    tick();
    idle_inputs();
    chk("mis_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("mis_d_err", 32'(d_err), 32'd1);
    chk("mis_d_rdata", d_rdata, 32'h0);
    chk("mis_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("mis_if_rdata", if_rdata, 32'hC0DE_0010);

    // Misaligned write alone: no SRAM access, error response.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'hF;
    d_addr  = 32'h21;
    d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("misw_gnt", 32'(d_gnt), 32'd1);
    chk("misw_en", 32'(sram_en), 32'd0);
    chk("misw_we", 32'(sram_we), 32'd0);
    tick();
    idle_inputs();
    chk("misw_rvalid", 32'(d_rvalid), 32'd1);
    chk("misw_err", 32'(d_err), 32'd1);
    #1;
    tick();
    chk("misw_done_rvalid", 32'(d_rvalid), 32'd0);
    chk("misw_done_err", 32'(d_err), 32'd0);

    // Build up fetch starvation, then reset right after a data read grant.
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_addr  = 32'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_mid_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'h0);
    chk("rst_mid_d_err", 32'(d_err), 32'd0);
    chk("rst_mid_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_mid_en", 32'(sram_en), 32'd0);
    tick();
    chk("rst_hold_d_rvalid", 32'(d_rvalid), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_rel_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    chk("rst_after_d_rvalid", 32'(d_rvalid), 32'd0);
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_addr  = 32'h30;
    #1;
    chk("post_rst_d_gnt", 32'(d_gnt), 32'd1);
    chk("post_rst_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    chk("post_rst_d_rdata", d_rdata, 32'hC0DE_000C);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
